// File: rtl/ram_arbiter_pkg.sv
// ============================================================================
// Module : ram_arbiter_pkg
// Brief  : Shared widths, FSM encoding and port ids for the RAM arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package ram_arbiter_pkg;

    localparam int DEF_ADDR_WIDTH = 14;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_if.sv
// ============================================================================
// Module : ram_arbiter_if
// Brief  : REQ/ACK requester bundle; master = requester, slave = arbiter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] di;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, di, input  ack, rdata);
    modport slave  (input  req, we, addr, di, output ack, rdata);
endinterface

`default_nettype wire

// File: rtl/ram_arbiter_rr_arbiter2.sv
// ============================================================================
// Module : rr_arbiter2
// Brief  : Combinational two-way grant, round-robin or fixed A-priority.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter2
    import ram_arbiter_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0
) (
    input  wire logic req_a_i,
    input  wire logic req_b_i,
    input  wire logic last_grant_i,
    output logic      valid_o,
    output logic      gnt_o
);

    always_comb begin
        valid_o = req_a_i | req_b_i;
        gnt_o   = PORT_A;
        if (req_a_i && req_b_i) begin
            if (FIXED_PRIORITY != 0) gnt_o = PORT_A;
            else                     gnt_o = (last_grant_i == PORT_A) ? PORT_B : PORT_A;
        end else if (req_b_i) begin
            gnt_o = PORT_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ============================================================================
// Module : ram_arbiter
// Brief  : Two-requester sequencer owning all pins of a single-port sync RAM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int FIXED_PRIORITY = 0
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    ram_arbiter_if.slave               a_if,
    ram_arbiter_if.slave               b_if,
    output logic [ADDR_WIDTH-1:0]      ram_addr_o,
    output logic                       ram_we_o,
    output logic                       ram_cs_o,
    output logic [DATA_WIDTH-1:0]      ram_di_o,
    input  wire logic [DATA_WIDTH-1:0] ram_do_i,
    output logic                       busy_o
);

    state_t                state_q,    state_d;
    logic                  gnt_q,      gnt_d;
    logic                  last_q,     last_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_di_q,   ram_di_d;
    logic                  ram_we_q,   ram_we_d;
    logic                  ram_cs_q,   ram_cs_d;
    logic                  busy_q,     busy_d;
    logic                  a_ack_q,    a_ack_d;
    logic                  b_ack_q,    b_ack_d;
    logic [DATA_WIDTH-1:0] a_do_q,     a_do_d;
    logic [DATA_WIDTH-1:0] b_do_q,     b_do_d;

    logic elig_a, elig_b, arb_valid, arb_gnt;

    // A request is masked during its own ACK cycle so it cannot be re-accepted.
    assign elig_a = a_if.req && !a_ack_q;
    assign elig_b = b_if.req && !b_ack_q;

    rr_arbiter2 #(
        .FIXED_PRIORITY (FIXED_PRIORITY)
    ) u_arb (
        .req_a_i      (elig_a),
        .req_b_i      (elig_b),
        .last_grant_i (last_q),
        .valid_o      (arb_valid),
        .gnt_o        (arb_gnt)
    );

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_d     = last_q;
        ram_addr_d = ram_addr_q;
        ram_di_d   = ram_di_q;
        ram_we_d   = ram_we_q;
        ram_cs_d   = ram_cs_q;
        busy_d     = busy_q;
        a_ack_d    = 1'b0;
        b_ack_d    = 1'b0;
        a_do_d     = a_do_q;
        b_do_d     = b_do_q;

        case (state_q)
            ST_IDLE: begin
                if (arb_valid) begin
                    gnt_d      = arb_gnt;
                    ram_addr_d = (arb_gnt == PORT_B) ? b_if.addr : a_if.addr;
                    ram_di_d   = (arb_gnt == PORT_B) ? b_if.di   : a_if.di;
                    ram_we_d   = (arb_gnt == PORT_B) ? b_if.we   : a_if.we;
                    ram_cs_d   = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (!ram_we_q) begin
                    if (gnt_q == PORT_B) b_do_d = ram_do_i;
                    else                 a_do_d = ram_do_i;
                end
                if (gnt_q == PORT_B) b_ack_d = 1'b1;
                else                 a_ack_d = 1'b1;
                ram_cs_d = 1'b0;
                ram_we_d = 1'b0;
                busy_d   = 1'b0;
                last_d   = gnt_q;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= PORT_A;
            last_q     <= PORT_B;
            ram_addr_q <= '0;
            ram_di_q   <= '0;
            ram_we_q   <= 1'b0;
            ram_cs_q   <= 1'b0;
            busy_q     <= 1'b0;
            a_ack_q    <= 1'b0;
            b_ack_q    <= 1'b0;
            a_do_q     <= '0;
            b_do_q     <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_q     <= last_d;
            ram_addr_q <= ram_addr_d;
            ram_di_q   <= ram_di_d;
            ram_we_q   <= ram_we_d;
            ram_cs_q   <= ram_cs_d;
            busy_q     <= busy_d;
            a_ack_q    <= a_ack_d;
            b_ack_q    <= b_ack_d;
            a_do_q     <= a_do_d;
            b_do_q     <= b_do_d;
        end
    end

    assign ram_addr_o = ram_addr_q;
    assign ram_di_o   = ram_di_q;
    assign ram_we_o   = ram_we_q;
    assign ram_cs_o   = ram_cs_q;
    assign busy_o     = busy_q;
    assign a_if.ack   = a_ack_q;
    assign b_if.ack   = b_ack_q;
    assign a_if.rdata = a_do_q;
    assign b_if.rdata = b_do_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_arbiter.sv
// ============================================================================
// Module : tb_ram_arbiter
// Brief  : Directed bench: round-robin DUT on a RAM model plus a fixed-priority DUT.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    ram_arbiter_if a_if ();
    ram_arbiter_if b_if ();
    ram_arbiter_if af_if ();
    ram_arbiter_if bf_if ();

    logic [13:0] ram_addr;
    logic        ram_we, ram_cs, busy;
    logic [7:0]  ram_di;
    logic [7:0]  ram_do;
    logic [7:0]  mem [0:16383];

    logic [13:0] f_addr;
    logic        f_we, f_cs, f_busy;
    logic [7:0]  f_di;
    logic [7:0]  f_do = 8'h00;

    ram_arbiter #(.FIXED_PRIORITY(0)) dut (
        .clk(clk), .rst(rst), .a_if(a_if), .b_if(b_if),
        .ram_addr_o(ram_addr), .ram_we_o(ram_we), .ram_cs_o(ram_cs),
        .ram_di_o(ram_di), .ram_do_i(ram_do), .busy_o(busy)
    );

    ram_arbiter #(.FIXED_PRIORITY(1)) dut_fix (
        .clk(clk), .rst(rst), .a_if(af_if), .b_if(bf_if),
        .ram_addr_o(f_addr), .ram_we_o(f_we), .ram_cs_o(f_cs),
        .ram_di_o(f_di), .ram_do_i(f_do), .busy_o(f_busy)
    );

    // Single-port RAM: sync write, async read, DI forwarded while writing.
    always @(posedge clk) if (ram_cs && ram_we) mem[ram_addr] <= ram_di;
    assign ram_do = !ram_cs ? 8'hzz : (ram_we ? ram_di : mem[ram_addr]);

    int na = 0, nb = 0, ncs = 0;
    always @(negedge clk) begin
        if (a_if.ack) na++;
        if (b_if.ack) nb++;
        if (ram_cs)   ncs++;
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Issues one request from a negedge and returns the number of cycles to ACK.
    task automatic drive_access(input logic port, input logic we, input logic [13:0] addr,
                                input logic [7:0] di, output int lat);
        logic got;
        if (port) begin b_if.we = we; b_if.addr = addr; b_if.di = di; b_if.req = 1'b1; end
        else      begin a_if.we = we; a_if.addr = addr; a_if.di = di; a_if.req = 1'b1; end
        lat = 0;
        got = 1'b0;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            got = port ? b_if.ack : a_if.ack;
        end
        a_if.req = 1'b0;
        b_if.req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (a_if.ack !== 1'b0 || b_if.ack !== 1'b0) begin bad++; $display("FAIL reset_ack got a=%b b=%b want 0 0", a_if.ack, b_if.ack); end
        total++; if (ram_cs !== 1'b0 || ram_we !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL reset_ctrl got cs=%b we=%b busy=%b want 0 0 0", ram_cs, ram_we, busy); end
        total++; if (ram_addr !== 14'h0 || ram_di !== 8'h0) begin bad++; $display("FAIL reset_pins got addr=%h di=%h want 0 0", ram_addr, ram_di); end
        total++; if (a_if.rdata !== 8'h0 || b_if.rdata !== 8'h0) begin bad++; $display("FAIL reset_do got a=%h b=%h want 0 0", a_if.rdata, b_if.rdata); end
    endtask

    task automatic test_single_a();
        int lat, nb0;
        nb0 = nb;
        drive_access(1'b0, 1'b1, 14'h3FFF, 8'hA5, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL a_write_lat got %0d want 2", lat); end
        total++; if (mem[14'h3FFF] !== 8'hA5) begin bad++; $display("FAIL a_write_mem got %h want a5", mem[14'h3FFF]); end
        drive_access(1'b0, 1'b0, 14'h3FFF, 8'h00, lat);
        total++; if (lat !== 2) begin bad++; $display("FAIL a_read_lat got %0d want 2", lat); end
        total++; if (a_if.rdata !== 8'hA5) begin bad++; $display("FAIL a_read_do got %h want a5", a_if.rdata); end
        total++; if (nb !== nb0) begin bad++; $display("FAIL b_ack_idle got %0d pulses want 0", nb - nb0); end
    endtask

    task automatic test_simultaneous();
        int ta, tb_;
        apply_reset();
        a_if.we = 1'b0; a_if.addr = 14'h3FFF; a_if.di = 8'h00;
        b_if.we = 1'b1; b_if.addr = 14'h0001; b_if.di = 8'h5A;
        a_if.req = 1'b1; b_if.req = 1'b1;
        ta = 0; tb_ = 0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (a_if.ack) begin ta = c; a_if.req = 1'b0; end
            if (b_if.ack) begin tb_ = c; b_if.req = 1'b0; end
        end
        a_if.req = 1'b0; b_if.req = 1'b0;
        total++; if (ta !== 2) begin bad++; $display("FAIL sim_a_ack_cycle got %0d want 2", ta); end
        total++; if (tb_ !== 4) begin bad++; $display("FAIL sim_b_ack_cycle got %0d want 4", tb_); end
        total++; if (mem[14'h0001] !== 8'h5A) begin bad++; $display("FAIL sim_b_mem got %h want 5a", mem[14'h0001]); end
        total++; if (a_if.rdata !== 8'hA5) begin bad++; $display("FAIL sim_a_do got %h want a5", a_if.rdata); end
    endtask

    // The ACK mask makes a port ineligible in its own ACK cycle, so under continuous
    // load both variants alternate; priority only decides fresh ties.
    task automatic test_continuous();
        int ka, kb, fa, fb, k, fk;
        apply_reset();
        a_if.we = 1'b0; a_if.addr = 14'h3FFF; b_if.we = 1'b0; b_if.addr = 14'h0001;
        af_if.we = 1'b0; af_if.addr = 14'h0; af_if.di = 8'h0;
        bf_if.we = 1'b0; bf_if.addr = 14'h0; bf_if.di = 8'h0;
        a_if.req = 1'b1; b_if.req = 1'b1; af_if.req = 1'b1; bf_if.req = 1'b1;
        ka = 0; kb = 0; fa = 0; fb = 0; k = 0; fk = 0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (a_if.ack || b_if.ack) begin
                total++;
                if (a_if.ack !== (k % 2 == 0) || b_if.ack !== (k % 2 == 1)) begin
                    bad++; $display("FAIL rr_order ack#%0d got a=%b b=%b want %s", k, a_if.ack, b_if.ack, (k % 2 == 0) ? "A" : "B");
                end
                k++;
            end
            if (af_if.ack || bf_if.ack) begin
                total++;
                if (af_if.ack !== (fk % 2 == 0) || bf_if.ack !== (fk % 2 == 1)) begin
                    bad++; $display("FAIL fix_order ack#%0d got a=%b b=%b", fk, af_if.ack, bf_if.ack);
                end
                fk++;
            end
            if (a_if.ack) ka++;
            if (b_if.ack) kb++;
            if (af_if.ack) fa++;
            if (bf_if.ack) fb++;
        end
        a_if.req = 1'b0; b_if.req = 1'b0; af_if.req = 1'b0; bf_if.req = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (ka !== 4 || kb !== 4) begin bad++; $display("FAIL rr_counts got a=%0d b=%0d want 4 4", ka, kb); end
        total++; if (fa !== 4 || fb !== 4) begin bad++; $display("FAIL fix_counts got a=%0d b=%0d want 4 4", fa, fb); end
    endtask

    task automatic test_tie_priority();
        int ra, rb, xa, xb;
        apply_reset();
        // One A access on both DUTs so last_grant becomes A.
        a_if.we = 1'b0; a_if.addr = 14'h3FFF; af_if.we = 1'b0; af_if.addr = 14'h0;
        a_if.req = 1'b1; af_if.req = 1'b1;
        repeat (2) @(negedge clk);
        a_if.req = 1'b0; af_if.req = 1'b0;
        @(negedge clk);
        b_if.we = 1'b0; b_if.addr = 14'h0001;
        a_if.req = 1'b1; b_if.req = 1'b1; af_if.req = 1'b1; bf_if.req = 1'b1;
        ra = 0; rb = 0; xa = 0; xb = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (a_if.ack)  begin ra = c; a_if.req  = 1'b0; end
            if (b_if.ack)  begin rb = c; b_if.req  = 1'b0; end
            if (af_if.ack) begin xa = c; af_if.req = 1'b0; end
            if (bf_if.ack) begin xb = c; bf_if.req = 1'b0; end
        end
        a_if.req = 1'b0; b_if.req = 1'b0; af_if.req = 1'b0; bf_if.req = 1'b0;
        total++; if (rb !== 2 || ra !== 4) begin bad++; $display("FAIL rr_tie got b@%0d a@%0d want b@2 a@4", rb, ra); end
        total++; if (xa !== 2 || xb !== 4) begin bad++; $display("FAIL fix_tie got a@%0d b@%0d want a@2 b@4", xa, xb); end
    endtask

    task automatic test_back_to_back();
        int na0, cs0, tb_;
        apply_reset();
        na0 = na; cs0 = ncs; tb_ = 0;
        a_if.we = 1'b0; a_if.addr = 14'h3FFF; a_if.req = 1'b1;
        @(negedge clk);
        b_if.we = 1'b0; b_if.addr = 14'h0001; b_if.req = 1'b1;
        for (int c = 2; c <= 8; c++) begin
            @(negedge clk);
            if (c == 3) a_if.req = 1'b0;
            if (b_if.ack) begin tb_ = c; b_if.req = 1'b0; end
        end
        total++; if (tb_ !== 4) begin bad++; $display("FAIL b2b_b_ack got %0d want 4", tb_); end
        total++; if (na - na0 !== 1) begin bad++; $display("FAIL b2b_a_acks got %0d want 1", na - na0); end
        total++; if (ncs - cs0 !== 2) begin bad++; $display("FAIL b2b_accesses got %0d want 2", ncs - cs0); end
    endtask

    task automatic test_reset_midop();
        int lat;
        a_if.we = 1'b1; a_if.addr = 14'h0100; a_if.di = 8'h11; a_if.req = 1'b1;
        @(negedge clk);
        total++; if (busy !== 1'b1 || ram_we !== 1'b1) begin bad++; $display("FAIL midop_access got busy=%b we=%b want 1 1", busy, ram_we); end
        rst = 1'b1; a_if.req = 1'b0;
        @(negedge clk);
        total++; if (a_if.ack !== 1'b0) begin bad++; $display("FAIL midop_ack got %b want 0", a_if.ack); end
        total++; if (busy !== 1'b0 || ram_cs !== 1'b0 || ram_addr !== 14'h0 || a_if.rdata !== 8'h0) begin
            bad++; $display("FAIL midop_outs got busy=%b cs=%b addr=%h ado=%h want 0 0 0 0", busy, ram_cs, ram_addr, a_if.rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        drive_access(1'b0, 1'b0, 14'h0100, 8'h00, lat);
        total++; if (lat !== 2 || a_if.rdata !== 8'h11) begin bad++; $display("FAIL midop_readback got lat=%0d do=%h want 2 11", lat, a_if.rdata); end
    endtask

    task automatic test_write_then_read();
        int lat;
        drive_access(1'b1, 1'b0, 14'h0001, 8'h00, lat);
        total++; if (b_if.rdata !== 8'h5A) begin bad++; $display("FAIL b_read_do got %h want 5a", b_if.rdata); end
        drive_access(1'b1, 1'b1, 14'h0002, 8'h77, lat);
        total++; if (b_if.rdata !== 8'h5A) begin bad++; $display("FAIL b_do_on_write got %h want 5a", b_if.rdata); end
        drive_access(1'b0, 1'b0, 14'h0002, 8'h00, lat);
        total++; if (a_if.rdata !== 8'h77) begin bad++; $display("FAIL a_read_b_write got %h want 77", a_if.rdata); end
    endtask

    initial begin
        a_if.req = 1'b0; a_if.we = 1'b0; a_if.addr = '0; a_if.di = '0;
        b_if.req = 1'b0; b_if.we = 1'b0; b_if.addr = '0; b_if.di = '0;
        af_if.req = 1'b0; af_if.we = 1'b0; af_if.addr = '0; af_if.di = '0;
        bf_if.req = 1'b0; bf_if.we = 1'b0; bf_if.addr = '0; bf_if.di = '0;
        @(negedge clk);
        test_reset();
        test_single_a();
        test_simultaneous();
        test_continuous();
        test_tie_priority();
        test_back_to_back();
        test_reset_midop();
        test_write_then_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
